// File: rtl/keypad_item_requester.sv
// keypad_item_requester
//   Collects decimal digits from the keypad decoder into an item address,
//   range-checks it, and requests that item from the item selector using a
//   valid/ready handshake. Completion, entry errors and handshake timeouts are
//   reported to the front-panel controller.
//
// Ports
//   clk               in   system clock, rising edge
//   rstn              in   asynchronous active-low reset
//   key_valid         in   one-cycle strobe qualifying key_code
//   key_code[3:0]     in   0-9 digit, A CLEAR, B ENTER, C-F ignored
//   selection_ready   in   item selector can accept a request
//   item_select       out  requested item address (meaningful while valid)
//   item_select_valid out  request valid, held until accepted or aborted
//   busy              out  request in flight; keys are ignored
//   req_done          out  one-cycle pulse after an accepted transfer
//   req_error         out  one-cycle pulse on any error
//   err_code[1:0]     out  0 none, 1 digit overflow, 2 out of range, 3 timeout
module keypad_item_requester #(
  parameter int ITEM_ADDR_WIDTH = 10,
  parameter int MAX_DIGITS      = 4,
  parameter int MAX_ITEMS       = 1000,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       key_valid,
  input  logic [3:0]                 key_code,
  input  logic                       selection_ready,
  output logic [ITEM_ADDR_WIDTH-1:0] item_select,
  output logic                       item_select_valid,
  output logic                       busy,
  output logic                       req_done,
  output logic                       req_error,
  output logic [1:0]                 err_code
);

  localparam int ACC_W = ITEM_ADDR_WIDTH + 4;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [ACC_W-1:0] ACC_LIMIT = ACC_W'(MAX_ITEMS);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_DIGITS);
  // Abort on the edge that ends the TIMEOUT_CYCLES-th REQ cycle.
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_REQ   = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic [ITEM_ADDR_WIDTH-1:0] item_q, item_d;
  logic [1:0]                 err_code_q, err_code_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;

  logic is_digit, is_clear, is_enter;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_clear = key_valid && (key_code == 4'hA);
  assign is_enter = key_valid && (key_code == 4'hB);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      item_q     <= '0;
      err_code_q <= ERR_NONE;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      item_q     <= item_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    item_d     = item_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // ENTER/CLEAR with no digits pending are deliberately no-ops.
        if (is_digit) begin
          acc_d   = ACC_W'(key_code);
          cnt_d   = CNT_W'(1);
          state_d = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (is_digit) begin
          if (cnt_q == CNT_MAX) begin
            error_d    = 1'b1;
            err_code_d = ERR_OVERFLOW;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = S_IDLE;
          end else begin
            acc_d = acc_q * ACC_W'(10) + ACC_W'(key_code);
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (is_clear) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (is_enter) begin
          if (acc_q >= ACC_LIMIT) begin
            error_d    = 1'b1;
            err_code_d = ERR_RANGE;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = S_IDLE;
          end else begin
            err_code_d = ERR_NONE;
            item_d     = acc_q[ITEM_ADDR_WIDTH-1:0];
            tmo_d      = '0;
            state_d    = S_REQ;
          end
        end
      end

      S_REQ: begin
        // Transfer is checked first so a handshake on the expiry edge wins.
        if (selection_ready) begin
          done_d  = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          error_d    = 1'b1;
          err_code_d = ERR_TIMEOUT;
          acc_d      = '0;
          cnt_d      = '0;
          tmo_d      = '0;
          state_d    = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs; valid/busy decode straight from the state flop so reset drops
  // them asynchronously.
  always_comb begin
    item_select_valid = (state_q == S_REQ);
    busy              = (state_q == S_REQ);
    item_select       = item_q;
    req_done          = done_q;
    req_error         = error_q;
    err_code          = err_code_q;
  end

endmodule

// File: tb/tb_keypad_item_requester.sv
module tb_keypad_item_requester;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       selection_ready = 1'b0;
  logic [9:0] item_select;
  logic       item_select_valid;
  logic       busy;
  logic       req_done;
  logic       req_error;
  logic [1:0] err_code;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the sticky outputs, carried across scenarios.
  int exp_err  = 0;
  int exp_item = 0;

  keypad_item_requester dut (
    .clk               (clk),
    .rstn              (rstn),
    .key_valid         (key_valid),
    .key_code          (key_code),
    .selection_ready   (selection_ready),
    .item_select       (item_select),
    .item_select_valid (item_select_valid),
    .busy              (busy),
    .req_done          (req_done),
    .req_error         (req_error),
    .err_code          (err_code)
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {item_select_valid, busy, req_done, req_error, err_code, item_select};

  function automatic logic [15:0] vec(input bit v, input bit b, input bit d,
                                      input bit e, input int ec, input int item);
    return {v, b, d, e, 2'(ec), 10'(item)};
  endfunction

  // One clock; leaves us 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a key for exactly one sampling edge.
  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    cycle();
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want %h", obs, 16'h0);
    end
    @(negedge clk);
    rstn = 1'b1;
    cycle();
    exp_err = 0;
    exp_item = 0;
  endtask

  task automatic test_basic();
    logic [15:0] e;
    selection_ready = 1'b1;
    press(4'd1);
    press(4'd0);
    press(4'hB);
    e = vec(1, 1, 0, 0, 0, 10);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL basic_valid: got %h want %h", obs, e); end
    cycle();
    e = vec(0, 0, 1, 0, 0, 10);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL basic_done: got %h want %h", obs, e); end
    cycle();
    e = vec(0, 0, 0, 0, 0, 10);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL basic_idle: got %h want %h", obs, e); end
    selection_ready = 1'b0;
    exp_err = 0;
    exp_item = 10;
  endtask

  task automatic test_stall();
    logic [15:0] e;
    selection_ready = 1'b0;
    press(4'd2);
    press(4'd5);
    press(4'hB);
    for (int i = 0; i < 4; i++) begin
      e = vec(1, 1, 0, 0, 0, 25);
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs, e); end
      if (i == 1) begin key_valid = 1'b1; key_code = 4'd7; end
      if (i == 3) selection_ready = 1'b1;
      cycle();
      key_valid = 1'b0;
    end
    e = vec(0, 0, 1, 0, 0, 25);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL stall_done: got %h want %h", obs, e); end
    selection_ready = 1'b0;
    // The 7 pressed in REQ must not have started an entry: a bare ENTER is a no-op.
    press(4'hB);
    e = vec(0, 0, 0, 0, 0, 25);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL stall_key_ignored: got %h want %h", obs, e); end
    exp_item = 25;
  endtask

  task automatic test_range();
    logic [15:0] e;
    press(4'd1); press(4'd0); press(4'd2); press(4'd4);
    press(4'hB);
    e = vec(0, 0, 0, 1, 2, 25);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL range_error: got %h want %h", obs, e); end
    cycle();
    e = vec(0, 0, 0, 0, 2, 25);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL range_pulse_end: got %h want %h", obs, e); end
    selection_ready = 1'b1;
    press(4'd5); press(4'd0);
    press(4'hB);
    e = vec(1, 1, 0, 0, 0, 50);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL range_recover_valid: got %h want %h", obs, e); end
    cycle();
    e = vec(0, 0, 1, 0, 0, 50);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL range_recover_done: got %h want %h", obs, e); end
    selection_ready = 1'b0;
    cycle();
    exp_err = 0;
    exp_item = 50;
  endtask

  task automatic test_overflow();
    logic [15:0] e;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    press(4'd5);
    e = vec(0, 0, 0, 1, 1, 50);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL overflow_error: got %h want %h", obs, e); end
    press(4'd9);
    press(4'hA);
    press(4'hB);
    for (int i = 0; i < 3; i++) begin
      e = vec(0, 0, 0, 0, 1, 50);
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL overflow_clear_quiet[%0d]: got %h want %h", i, obs, e); end
      cycle();
    end
    exp_err = 1;
  endtask

  task automatic test_timeout();
    logic [15:0] e;
    selection_ready = 1'b0;
    press(4'd3);
    press(4'hB);
    for (int i = 0; i < 255; i++) begin
      e = vec(1, 1, 0, 0, 0, 3);
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL timeout_hold[%0d]: got %h want %h", i, obs, e); end
      cycle();
    end
    e = vec(0, 0, 0, 1, 3, 3);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL timeout_error: got %h want %h", obs, e); end
    cycle();
    e = vec(0, 0, 0, 0, 3, 3);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL timeout_after: got %h want %h", obs, e); end
    exp_err = 3;
    exp_item = 3;
  endtask

  task automatic test_reset_mid_req();
    logic [15:0] e;
    selection_ready = 1'b0;
    press(4'd7);
    press(4'hB);
    repeat (5) cycle();
    e = vec(1, 1, 0, 0, 0, 7);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL midreset_pre: got %h want %h", obs, e); end
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 16'h0) begin n_bad++; $display("FAIL midreset_async: got %h want %h", obs, 16'h0); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cycle();
    n_cmp++;
    if (obs !== 16'h0) begin n_bad++; $display("FAIL midreset_no_pulse: got %h want %h", obs, 16'h0); end
    selection_ready = 1'b1;
    press(4'd4);
    press(4'hB);
    e = vec(1, 1, 0, 0, 0, 4);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL midreset_valid: got %h want %h", obs, e); end
    cycle();
    e = vec(0, 0, 1, 0, 0, 4);
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL midreset_done: got %h want %h", obs, e); end
    selection_ready = 1'b0;
    cycle();
    exp_err = 0;
    exp_item = 4;
  endtask

  // Random entries predicted at transaction level: the decimal value of the
  // digits typed and how long the selector stalls decide the whole outcome.
  task automatic test_random();
    logic [15:0] e;
    for (int n = 0; n < 40; n++) begin
      int nd  = $urandom_range(1, 5);
      int val = 0;
      int clr = ($urandom_range(0, 3) == 0);
      int r   = $urandom_range(0, 9);
      int d   = (r < 7) ? r : ((r == 7) ? 254 : ((r == 8) ? 255 : 1));
      for (int j = 0; j < nd; j++) begin
        int dg = $urandom_range(0, 9);
        selection_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
          press(4'hC + 4'($urandom_range(0, 3)));
          e = vec(0, 0, 0, 0, exp_err, exp_item);
          n_cmp++;
          if (obs !== e) begin n_bad++; $display("FAIL rnd_ignored_code[%0d]: got %h want %h", n, obs, e); end
        end
        press(4'(dg));
        if (j == 4) begin
          exp_err = 1;
          e = vec(0, 0, 0, 1, exp_err, exp_item);
        end else begin
          val = val * 10 + dg;
          e = vec(0, 0, 0, 0, exp_err, exp_item);
        end
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL rnd_digit[%0d.%0d]: got %h want %h", n, j, obs, e); end
      end
      if (nd <= 4) begin
        if (clr) begin
          press(4'hA);
          e = vec(0, 0, 0, 0, exp_err, exp_item);
          n_cmp++;
          if (obs !== e) begin n_bad++; $display("FAIL rnd_clear[%0d]: got %h want %h", n, obs, e); end
        end else if (val >= 1000) begin
          press(4'hB);
          exp_err = 2;
          e = vec(0, 0, 0, 1, exp_err, exp_item);
          n_cmp++;
          if (obs !== e) begin n_bad++; $display("FAIL rnd_range[%0d]: got %h want %h", n, obs, e); end
        end else begin
          int ncyc = (d >= 255) ? 255 : d + 1;
          press(4'hB);
          exp_err  = 0;
          exp_item = val;
          for (int i = 0; i < ncyc; i++) begin
            selection_ready = (i >= d);
            key_valid = 1'($urandom_range(0, 1));
            key_code  = 4'($urandom_range(0, 15));
            e = vec(1, 1, 0, 0, exp_err, exp_item);
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL rnd_req[%0d.%0d]: got %h want %h", n, i, obs, e); end
            cycle();
          end
          key_valid = 1'b0;
          if (d < 255) begin
            e = vec(0, 0, 1, 0, exp_err, exp_item);
          end else begin
            exp_err = 3;
            e = vec(0, 0, 0, 1, exp_err, exp_item);
          end
          n_cmp++;
          if (obs !== e) begin n_bad++; $display("FAIL rnd_end[%0d]: got %h want %h", n, obs, e); end
        end
      end
      selection_ready = 1'b0;
      cycle();
      e = vec(0, 0, 0, 0, exp_err, exp_item);
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL rnd_idle[%0d]: got %h want %h", n, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_range();
    test_overflow();
    test_timeout();
    test_reset_mid_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
